// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified bus arbiter: mask encoding, FSM states, grant owner.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10
    } mask_e;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY,
        RESP
    } state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    // Mask 11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] lo);
        case (mask)
            MASK_BYTE: return 1'b0;
            MASK_HALF: return lo[0];
            default:   return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: store strobes/data replication and load lane extract/extend.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  mask,
    input  logic [1:0]  addr_lo,
    input  logic        sign_extend,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lanes,
    input  logic [31:0] rdata_bus,
    output logic [31:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata_bus[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? rdata_bus[31:16] : rdata_bus[15:0];

    always_comb begin
        wstrb       = 4'b1111;
        wdata_lanes = wdata;
        rdata       = rdata_bus;
        case (mask)
            MASK_BYTE: begin
                wstrb       = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata       = {{24{sign_extend & lane_b[7]}}, lane_b};
            end
            MASK_HALF: begin
                wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata       = {{16{sign_extend & lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory bus arbiter between instruction fetch and the MEM load/store path.
// Optional MEM_ARB_MISALIGN_CHECK_EN rejects misaligned half/word accesses with bus_error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_mask,
    input  logic        mem_sign_extend,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        bus_error
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e      state;
    grant_e      last_grant;
    logic [31:0] wait_cnt;
    logic [1:0]  r_mask, r_lo;
    logic        r_sign;

    logic        mem_pend, mem_wins, misalign, timeout_hit;
    logic [1:0]  a_mask, a_lo;
    logic        a_sign;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_rdata;
    logic        unused_if_lo;

    assign unused_if_lo = ^if_addr[1:0];
    assign mem_pend     = mem_read | mem_write;
    // MEM normally wins; IF gets the bus after a MEM grant so fetch never starves.
    assign mem_wins     = mem_pend & ~((last_grant == GRANT_MEM) & if_req);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
    assign stall_if     = if_req & ~if_done;
    assign stall_mem    = mem_pend & ~mem_done;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(mem_mask, mem_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Live request drives strobes at grant; the latched copy drives load alignment later.
    assign a_mask = (state == IDLE) ? mem_mask        : r_mask;
    assign a_lo   = (state == IDLE) ? mem_addr[1:0]   : r_lo;
    assign a_sign = (state == IDLE) ? mem_sign_extend : r_sign;

    mem_lane_align u_align (
        .mask        (a_mask),
        .addr_lo     (a_lo),
        .sign_extend (a_sign),
        .wdata       (mem_wdata),
        .wstrb       (al_wstrb),
        .wdata_lanes (al_wdata),
        .rdata_bus   (bus_rdata),
        .rdata       (al_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            wait_cnt   <= '0;
            r_mask     <= '0;
            r_lo       <= '0;
            r_sign     <= 1'b0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            mem_rdata  <= '0;
            mem_done   <= 1'b0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            bus_error  <= 1'b0;
        end else begin
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (mem_wins) begin
                        last_grant <= GRANT_MEM;
                        r_mask     <= mem_mask;
                        r_lo       <= mem_addr[1:0];
                        r_sign     <= mem_sign_extend;
                        if (misalign) begin
                            state     <= RESP;
                            mem_done  <= 1'b1;
                            bus_error <= 1'b1;
                            mem_rdata <= '0;
                        end else begin
                            state     <= MEM_BUSY;
                            bus_valid <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {mem_addr[31:2], 2'b00};
                            bus_wstrb <= mem_write ? al_wstrb : 4'b0000;
                            bus_wdata <= mem_write ? al_wdata : 32'h0;
                        end
                    end else if (if_req) begin
                        last_grant <= GRANT_IF;
                        state      <= IF_BUSY;
                        bus_valid  <= 1'b1;
                        bus_we     <= 1'b0;
                        bus_addr   <= {if_addr[31:2], 2'b00};
                        bus_wstrb  <= 4'b0000;
                        bus_wdata  <= 32'h0;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (bus_ready || timeout_hit) begin
                        bus_valid <= 1'b0;
                        bus_error <= ~bus_ready;
                        state     <= RESP;
                        if (state == IF_BUSY) begin
                            if_done  <= 1'b1;
                            if_rdata <= bus_ready ? bus_rdata : 32'h0;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= bus_ready ? al_rdata : 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; honours MEM_ARB_MISALIGN_CHECK_EN for the misalign step.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_mask;
    logic        mem_sign_extend;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_if, stall_mem;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_error;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_sign_extend(mem_sign_extend),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_mask = 2'b10; mem_sign_extend = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus_valid, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_error", bus_error, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_stall", {stall_if, stall_mem}, 0);
        rstn = 1'b1;
        tick();

        // Lone fetch, two wait cycles
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("f_valid1", bus_valid, 1);
        chk("f_addr", bus_addr, 32'h100);
        chk("f_we", bus_we, 0);
        chk("f_stall", stall_if, 1);
        tick();
        chk("f_valid2", bus_valid, 1);
        tick();
        chk("f_valid3", bus_valid, 1);
        bus_ready = 1'b1; bus_rdata = 32'h13;
        tick();
        chk("f_done", if_done, 1);
        chk("f_rdata", if_rdata, 32'h13);
        chk("f_valid_off", bus_valid, 0);
        chk("f_stall_off", stall_if, 0);
        bus_ready = 1'b0;
        tick();
        chk("f_done_pulse", if_done, 0);
        chk("f_no_reissue", bus_valid, 0);
        if_req = 1'b0;
        tick();

        // Simultaneous IF + MEM: MEM first, then IF, then MEM again
        if_req = 1'b1; mem_read = 1'b1; mem_addr = 32'h2000; mem_mask = 2'b10;
        tick();
        chk("a_mem_first", bus_addr, 32'h2000);
        chk("a_stall_if", stall_if, 1);
        bus_ready = 1'b1; bus_rdata = 32'h11223344;
        tick();
        chk("a_mem_done", mem_done, 1);
        chk("a_mem_rdata", mem_rdata, 32'h11223344);
        chk("a_if_idle", if_done, 0);
        bus_ready = 1'b0;
        tick();
        chk("a_resp_nogrant", bus_valid, 0);
        tick();
        chk("a_if_second", bus_addr, 32'h100);
        chk("a_stall_mem", stall_mem, 1);
        bus_ready = 1'b1; bus_rdata = 32'h93;
        tick();
        chk("a_if_done", if_done, 1);
        chk("a_if_rdata", if_rdata, 32'h93);
        bus_ready = 1'b0; if_req = 1'b0;
        tick();
        tick();
        chk("a_mem_third", {31'(bus_addr), bus_valid}, {31'(32'h2000), 1'b1});
        bus_ready = 1'b1; bus_rdata = 32'h55667788;
        tick();
        chk("a_mem_done2", mem_done, 1);
        bus_ready = 1'b0; mem_read = 1'b0;
        tick();

        // Stores: byte to 0x1003, half to 0x1002
        mem_write = 1'b1; mem_addr = 32'h1003; mem_wdata = 32'hAB; mem_mask = 2'b00;
        tick();
        chk("sb_addr", bus_addr, 32'h1000);
        chk("sb_we", bus_we, 1);
        chk("sb_strb", bus_wstrb, 4'b1000);
        chk("sb_wdata", bus_wdata, 32'hABABABAB);
        bus_ready = 1'b1;
        tick();
        chk("sb_done", mem_done, 1);
        bus_ready = 1'b0; mem_addr = 32'h1002; mem_wdata = 32'h1234; mem_mask = 2'b01;
        tick();
        tick();
        chk("sh_strb", bus_wstrb, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'h12341234);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0; mem_write = 1'b0;
        tick();

        // Half loads from 0x2002, signed then unsigned; signed byte from 0x2001
        mem_read = 1'b1; mem_addr = 32'h2002; mem_mask = 2'b01; mem_sign_extend = 1'b1;
        tick();
        chk("lh_addr", bus_addr, 32'h2000);
        chk("lh_strb", bus_wstrb, 4'b0000);
        bus_ready = 1'b1; bus_rdata = 32'h8001BEEF;
        tick();
        chk("lh_signed", mem_rdata, 32'hFFFF8001);
        bus_ready = 1'b0; mem_sign_extend = 1'b0;
        tick();
        tick();
        bus_ready = 1'b1;
        tick();
        chk("lh_unsigned", mem_rdata, 32'h00008001);
        bus_ready = 1'b0; mem_addr = 32'h2001; mem_mask = 2'b00; mem_sign_extend = 1'b1;
        tick();
        tick();
        bus_ready = 1'b1; bus_rdata = 32'h0000F700;
        tick();
        chk("lb_signed", mem_rdata, 32'hFFFFFFF7);
        bus_ready = 1'b0; mem_read = 1'b0;
        tick();

        // Word load at 0x3002
        mem_read = 1'b1; mem_addr = 32'h3002; mem_mask = 2'b10; mem_sign_extend = 1'b0;
        tick();
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        chk("mis_valid", bus_valid, 0);
        chk("mis_error", bus_error, 1);
        chk("mis_done", mem_done, 1);
        chk("mis_rdata", mem_rdata, 0);
        mem_read = 1'b0;
        tick();
        chk("mis_err_pulse", bus_error, 0);
`else
        chk("trunc_valid", bus_valid, 1);
        chk("trunc_addr", bus_addr, 32'h3000);
        bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        chk("trunc_rdata", mem_rdata, 32'hCAFEF00D);
        chk("trunc_noerr", bus_error, 0);
        bus_ready = 1'b0; mem_read = 1'b0;
        tick();
`endif
        tick();

        // Timeout: bus_ready held low, limit 4
        mem_read = 1'b1; mem_addr = 32'h4000; mem_mask = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_valid%0d", i), {bus_valid, bus_error}, 2'b10);
        end
        tick();
        chk("to_valid_off", bus_valid, 0);
        chk("to_error", bus_error, 1);
        chk("to_done", mem_done, 1);
        chk("to_rdata", mem_rdata, 0);
        mem_read = 1'b0;
        tick();
        chk("to_err_pulse", bus_error, 0);
        tick();

        // Reset asserted mid MEM_BUSY
        mem_read = 1'b1; mem_addr = 32'h5000;
        tick();
        chk("rb_valid", bus_valid, 1);
        rstn = 1'b0;
        #1;
        chk("rb_async_drop", bus_valid, 0);
        bus_ready = 1'b1;
        tick();
        chk("rb_no_done", mem_done, 0);
        mem_read = 1'b0; bus_ready = 1'b0; rstn = 1'b1;
        tick();
        chk("rb_idle", {bus_valid, mem_done}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory bus between instruction fetch (IF) and the MEM stage's load/store path driven by the EX/MEM pipeline register. Grants one requester at a time, holds the transaction through a valid/ready bus handshake, and stalls the pipeline while the transaction is pending. Aligns byte and halfword data on writes (strobes) and on reads, including sign extension. Sits between the IF/MEM stages and the memory/peripheral interconnect.

## Interface
- TIMEOUT_CYCLES, 255: bus wait limit in cycles before aborting; 0 disables the timeout.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address, word aligned
- if_rdata  out  32  fetched word, valid when if_done
- if_done  out  1  one-cycle completion pulse
- mem_read, mem_write  in  1 each  load/store request, level, mutually exclusive
- mem_addr  in  32  byte address (EX/MEM ALU result)
- mem_wdata  in  32  store data, right-justified
- mem_mask  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_sign_extend  in  1  sign-extend load result
- mem_rdata  out  32  aligned load result, valid when mem_done
- mem_done  out  1  one-cycle completion pulse
- stall_if, stall_mem  out  1 each  stall the respective stage
- bus_valid  out  1  transaction valid; bus_we out 1; bus_addr out 32 (bits[1:0]=0); bus_wstrb out 4; bus_wdata out 32
- bus_ready  in  1  transaction accept/complete; bus_rdata in 32
- bus_error  out  1  one-cycle pulse on timeout (or misalignment, see Configuration)

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY, RESP.
- IDLE: when a MEM request (mem_read|mem_write) is pending it wins, except if last_grant==MEM and if_req is pending, in which case IF wins (no starvation). Grant → IF_BUSY/MEM_BUSY; last_grant updated.
- BUSY: bus_valid=1, bus_addr/we/wstrb/wdata registered at grant and held constant. On bus_ready=1: capture bus_rdata, go to RESP.
- RESP: assert the granted requester's done for exactly one cycle, then IDLE. No grant is made in RESP (the pipeline advances on this edge; the stale request must not be reissued).
- stall_if = if_req & ~if_done; stall_mem = (mem_read|mem_write) & ~mem_done.
- Write strobes: byte 0001<<addr[1:0], half 0011<<{addr[1],0}, word 1111; wdata replicated across lanes (byte ×4, half ×2).
- Read alignment: select lane by addr[1:0]/addr[1], zero- or sign-extend to 32 bits per mem_sign_extend; word passes through.
- Timeout: wait counter clears at grant; if it reaches TIMEOUT_CYCLES in BUSY, drop bus_valid, pulse bus_error, go to RESP with rdata=0.
- Deassertion of a request during BUSY does not abort the bus transaction; done still pulses.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant=IF, counter 0, captured data 0.
- Request visible in IDLE at cycle N → bus_valid at N+1 → bus_ready sampled at M≥N+1 → done at M+1 → IDLE at M+2, next bus_valid no earlier than M+3.
- Minimum of 3 cycles per access with zero-wait bus.
- rstn assertion mid-transaction drops bus_valid immediately (asynchronous); no done is generated.

## Configuration
- MEM_ARB_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is not issued; IDLE goes directly to RESP, bus_error pulses with mem_done, mem_rdata=0.
- Undefined: low address bits beyond lane selection are ignored; access is issued at the truncated alignment.

## Structure
- Shared package: mask encoding enum (MASK_BYTE/HALF/WORD), FSM state enum, grant enum.
- One sub-module: mem_lane_align (combinational strobe/wdata replication and load extraction/extension).

## Test plan
- Lone fetch if_addr=0x100, bus_ready after 2 wait cycles, bus_rdata=0x00000013 → bus_valid 3 cycles, if_done pulse with if_rdata=0x13, stall_if low after.
- Simultaneous if_req and mem_read → MEM granted first, then IF; repeated MEM requests alternate with pending IF.
- Store byte 0xAB to 0x1003 → bus_addr=0x1000, bus_wstrb=1000, bus_wdata=0xABABABAB.
- Load half from 0x2002, sign_extend=1, bus_rdata=0x8001xxxx → mem_rdata=0xFFFF8001; with sign_extend=0 → 0x00008001.
- bus_ready held low, TIMEOUT_CYCLES=4 → bus_error pulse after 4 cycles, mem_done with rdata 0, FSM IDLE.
- rstn low during MEM_BUSY → bus_valid 0 immediately, no done; macro build: word load at 0x3002 → bus_error+mem_done, no bus_valid.
